cache_line_assembler: RTL

- Write-side counterpart of the 128-way word-select read path. Assembles a 128-word cache line of W-bit words in a register.
- Two ways to load the line: random word merges at an index, or a sequential burst fill from memory.
- Hands the finished line downstream through a valid/ready handshake.
- line_out uses the same channel packing the read mux consumes, so it feeds that mux directly.

---
 rtl/cache_line_pkg.sv | 17 +
 rtl/we_decoder128.sv | 28 ++
 rtl/cache_line_assembler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cache_line_pkg.sv
// -----------------------------------------------------------------------------
// cache_line_pkg
// Shared definitions for the cache line assembler: line geometry and the
// controller state encoding.
// -----------------------------------------------------------------------------
package cache_line_pkg;

  localparam int LINE_WORDS = 128;  // words per cache line
  localparam int IDX_W      = 7;    // bits needed to index one word

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // random merges allowed, waiting for fill_start/commit
    FILL = 2'd1,  // sequential burst fill, word 0 upward
    HOLD = 2'd2   // line offered downstream, writes blocked
  } state_e;

endpackage

// File: rtl/we_decoder128.sv
// -----------------------------------------------------------------------------
// we_decoder128
// Combinational index-plus-enable to one-hot word write-enable decoder.
// Shared by the line register and the optional per-word mask.
//
// Ports:
//   idx_i  word index 0..127
//   en_i   write enable; all outputs are 0 when low
//   we_o   one-hot write enables, bit i selects word i
// -----------------------------------------------------------------------------
module we_decoder128
  import cache_line_pkg::*;
(
  input  logic [IDX_W-1:0]      idx_i,
  input  logic                  en_i,
  output logic [LINE_WORDS-1:0] we_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    we_o = '0;
    if (en_i) begin
      we_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_line_assembler.sv
// -----------------------------------------------------------------------------
// cache_line_assembler
// Assembles a 128-word line of W-bit words, loaded either by random merges at
// an index (IDLE) or by a sequential burst fill (FILL), then hands the line off
// through a valid/ready handshake (HOLD). Word i sits at line_out_o[i*W +: W],
// the packing the 128-way read mux consumes.
//
// Optional feature (macro CACHE_LINE_ASSEMBLER_WORD_MASK_EN): adds line_mask_o,
// one bit per word, set on each write and cleared on reset and on handoff.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   fill_start_i  IDLE: start a burst fill at word 0 (wins over commit_i)
//   commit_i      IDLE: offer the current line downstream
//   wr_valid_i    write word offered
//   wr_ready_o    write accepted this cycle (IDLE or FILL)
//   wr_sel_i      word index for IDLE merges, ignored in FILL
//   wr_data_i     word data
//   line_valid_o  line offered (HOLD)
//   line_ready_i  downstream accepts the line
//   line_out_o    line register
//   fill_cnt_o    next burst index
//   busy_o        state is not IDLE
//   line_mask_o   per-word written mask (optional)
// -----------------------------------------------------------------------------
module cache_line_assembler
  import cache_line_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_start_i,
  input  logic                    commit_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [IDX_W-1:0]        wr_sel_i,
  input  logic [W-1:0]            wr_data_i,
  output logic                    line_valid_o,
  input  logic                    line_ready_i,
  output logic [LINE_WORDS*W-1:0] line_out_o,
`ifdef CACHE_LINE_ASSEMBLER_WORD_MASK_EN
  output logic [LINE_WORDS-1:0]   line_mask_o,
`endif
  output logic [IDX_W-1:0]        fill_cnt_o,
  output logic                    busy_o
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [LINE_WORDS*W-1:0] line_q;
  logic [IDX_W-1:0]        wr_idx;
  logic [LINE_WORDS-1:0]   word_we;
  logic                    wr_fire;
  logic                    handoff;

  // Handshake outputs depend on state only, never combinationally on inputs.
  assign wr_ready_o   = (state_q != HOLD);
  assign line_valid_o = (state_q == HOLD);
  assign busy_o       = (state_q != IDLE);
  assign fill_cnt_o   = fill_cnt_q;
  assign line_out_o   = line_q;

  assign wr_fire = wr_valid_i & wr_ready_o;
  assign handoff = line_valid_o & line_ready_i;
  assign wr_idx  = (state_q == FILL) ? fill_cnt_q : wr_sel_i;

  we_decoder128 u_we_dec (
    .idx_i (wr_idx),
    .en_i  (wr_fire),
    .we_o  (word_we)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end else if (commit_i) begin
          state_d = HOLD;
        end
      end
      FILL: begin
        if (wr_fire) begin
          // Wraps to 0 on the last word, leaving the counter ready for the next fill.
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == IDX_W'(LINE_WORDS - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (line_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        fill_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // NOTE: the line storage is reset explicitly because a reset must discard any
  // partial line; a plain storage array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (word_we[i]) begin
          line_q[i*W +: W] <= wr_data_i;
        end
      end
    end
  end

`ifdef CACHE_LINE_ASSEMBLER_WORD_MASK_EN
  logic [LINE_WORDS-1:0] mask_q;

  // Write and clear never coincide: writes are blocked in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (handoff) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_q | word_we;
    end
  end

  assign line_mask_o = mask_q;
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule
